cl_dram_rd_arb: RTL
===================

// Module: cl_dram_rd_arb
// PURPOSE
//  Two-requester AXI read-channel arbiter in front of one DRAM crossbar slave port.
//  - Shares AR/R between the PCIS DMA path (port 0) and the RTL engine (port 1).
//  - Round-robin grant; per-port outstanding-burst limit; returns R beats to the owner via an ID tag bit.
//  - Sits between the requesters and the S_*_DRAM_AXI read side of cl_dram_xbar. Write channels are not touched.
// PARAMETERS
//  ID_W       6    requester ARID/RID width; downstream ID is ID_W+1 bits, with tag in MSB
//  ADDR_W     64   address width
//  DATA_W     512  read data width
//  MAX_OUTST  8    max outstanding AR bursts per port (1..255)
// PORTS
//  aclk                     in   1          clock
//  areset                   in   1          asynchronous reset, active high
//  s{0,1}_arvalid/arready   in/out 1        per-port AR handshake
//  s{0,1}_araddr            in   ADDR_W     AR address
//  s{0,1}_arid              in   ID_W       AR ID
//  s{0,1}_arlen/arsize      in   8/3        burst length-1 / beat size
//  s{0,1}_rvalid/rready     out/in 1        per-port R handshake
//  s{0,1}_rdata/rresp/rlast out  DATA_W/2/1 R payload
//  s{0,1}_rid               out  ID_W       R ID (tag stripped)
//  m_arvalid/arready        out/in 1        downstream AR handshake
//  m_araddr/arlen/arsize    out  ADDR_W/8/3 registered AR payload
//  m_arid                   out  ID_W+1     {port, s_arid}
//  m_rvalid/rready          in/out 1        downstream R handshake
//  m_rdata/rresp/rlast/rid  in   DATA_W/2/1/ID_W+1  R payload
//  err_underflow            out  1          sticky: R last beat seen for a port with zero outstanding
//  stat_clr                 in   1          clears statistics (see CONFIGURATION)
//  stat_grant0/1/stat_block out  32 each    statistics counters
// BEHAVIOUR
//  - Reset values: all s_arready, s_rvalid and m_arvalid are 0; m_ar* payload is 0; outstanding counters are 0;
//    rr_last is 1 (port 0 wins first tie); err_underflow is 0; state is IDLE. Reset mid-burst drops all state.
//  - Port i is eligible when s_i_arvalid && outst_i < MAX_OUTST.
//  - FSM IDLE:
//    - If any port is eligible, grant it. On a tie, grant !rr_last.
//    - The granted s_arready is 1 combinationally in this cycle; the other port's s_arready is 0.
//    - Capture the payload into the AR register, set rr_last to the granted port, increment outst of that port.
//    - Go to ISSUE.
//  - FSM ISSUE:
//    - m_arvalid=1 with a stable payload until m_arready.
//    - On handshake go to IDLE. No s_arready in ISSUE.
//  - Timing: AR latency from s handshake (cycle N) to m_arvalid is cycle N+1. Peak rate is 1 AR per 2 cycles.
//  - R path is combinational, with no state:
//    - sel = m_rid[ID_W]; s_sel_rvalid = m_rvalid; the other port's rvalid = 0.
//    - s_rid = m_rid[ID_W-1:0]; rdata/rresp/rlast are fanned out to both ports.
//    - m_rready = s_sel_rready.
//  - Outstanding counter decrements on m_rvalid && m_rready && m_rlast for port sel.
//    - Increment and decrement of the same port in one cycle leaves the counter unchanged.
//    - A decrement at 0 holds the counter at 0 and sets err_underflow. Cleared only by reset.
//  - At the limit: outst_i == MAX_OUTST holds s_i_arready at 0 and lets the other port win even without alternation.
//  - Counter width: $clog2(MAX_OUTST+1); never wraps.
// CONFIGURATION
//  - Macro: CL_DRAM_RD_ARB_STATS_EN.
//  - When defined, all counters are 32-bit, saturate at 32'hFFFF_FFFF, and are zeroed by stat_clr (stat_clr wins over an increment in the same cycle):
//    - stat_grant0/1 count AR grants per port.
//    - stat_block counts cycles in which some s_arvalid=1 with outst at MAX_OUTST.
//  - When undefined: the counters are not built, stat_* outputs are tied to 0, and stat_clr is ignored.
// TESTING
//  1. Single AR: s0 addr 0x1000, id 5, len 3 -> m_arvalid the next cycle, m_arid=7'h05.
//     Four R beats with rid 7'h05 reach s0 only; outst0 goes 1 then 0.
//  2. Both ports request continuously after reset -> grants alternate 0,1,0,1; m_arid MSB alternates; no starvation over 100 grants.
//  3. MAX_OUTST=2, s1 issues 3 ARs without R -> third held (s1_arready=0); s0 still granted.
//     One R last to s1 -> third AR issues within 2 cycles.
//  4. Same cycle: AR accept on s0 and R last for s0 with outst0=1 -> outst0 stays 1. m_arready held 0 for 10 cycles -> payload stable, no new grant.
//  5. R last with rid 7'h40 while outst1=0 -> err_underflow=1 and stays 1; outst1=0. areset pulse mid-ISSUE -> m_arvalid=0 immediately, counters 0.
//  6. STATS_EN: 5 grants port 0 and 3 grants port 1 -> stat_grant0=5, stat_grant1=3; stat_clr -> both 0 next cycle. Without macro -> all stat_* 0.

Source files
------------

// File: rtl/cl_dram_rd_arb_if.sv
// cl_dram_rd_arb_if: AXI read-channel (AR + R) bundle shared by requesters and the downstream port
// Signals: arvalid/arready, araddr, arid, arlen, arsize, rvalid/rready, rdata, rresp, rlast, rid.
// Modports: master drives AR and rready; slave drives arready and the R payload.
interface cl_dram_rd_arb_if #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  modport master (output arvalid, araddr, arid, arlen, arsize, rready,
                  input  arready, rvalid, rdata, rresp, rlast, rid);
  modport slave  (input  arvalid, araddr, arid, arlen, arsize, rready,
                  output arready, rvalid, rdata, rresp, rlast, rid);
endinterface

// File: rtl/cl_dram_rd_arb.sv
// cl_dram_rd_arb: two-port round-robin AXI read arbiter with per-port outstanding-burst limit
// Ports: aclk, areset (async, active high); s0/s1 requester AR/R (slave modport, ID_W ids);
//   m downstream AR/R (master modport, ID_W+1 ids, MSB tags the owning port);
//   err_underflow sticky R-last-without-outstanding flag; stat_clr, stat_grant0/1, stat_block counters.
// Optional: define CL_DRAM_RD_ARB_STATS_EN to build the saturating statistics counters;
//   otherwise stat_* read 0 and stat_clr is ignored.
module cl_dram_rd_arb #(
  parameter int ID_W      = 6,
  parameter int MAX_OUTST = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  cl_dram_rd_arb_if.slave          s0,
  cl_dram_rd_arb_if.slave          s1,
  cl_dram_rd_arb_if.master         m,
  output logic                     err_underflow,
  input  logic                     stat_clr,
  output logic [31:0]              stat_grant0,
  output logic [31:0]              stat_grant1,
  output logic [31:0]              stat_block
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t        state;
  logic          rr_last, idle, elig0, elig1, gnt0, gnt1, sel, rdone, dec0, dec1;
  logic [CW-1:0] outst0, outst1;
  assign idle  = state == IDLE && !areset;
  assign elig0 = s0.arvalid && outst0 < MAX_C;
  assign elig1 = s1.arvalid && outst1 < MAX_C;
  // rr_last names the last winner, so a tie goes to the other port
  assign gnt0  = idle && elig0 && (!elig1 || rr_last);
  assign gnt1  = idle && elig1 && (!elig0 || !rr_last);
  assign s0.arready = gnt0;
  assign s1.arready = gnt1;
  assign sel       = m.rid[ID_W];
  assign s0.rvalid = m.rvalid && !sel;
  assign s1.rvalid = m.rvalid && sel;
  assign s0.rid    = m.rid[ID_W-1:0];
  assign s1.rid    = m.rid[ID_W-1:0];
  assign s0.rdata  = m.rdata;
  assign s1.rdata  = m.rdata;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;
  assign m.rready  = sel ? s1.rready : s0.rready;
  assign rdone = m.rvalid && m.rready && m.rlast;
  assign dec0  = rdone && !sel;
  assign dec1  = rdone && sel;
  // simultaneous grant and burst completion cancel; a completion at zero is held at zero
  function automatic logic [CW-1:0] next_cnt(logic [CW-1:0] c, logic inc, logic dec);
    return inc == dec ? c : inc ? c + 1'b1 : c == '0 ? c : c - 1'b1;
  endfunction
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      rr_last       <= 1'b1;
      outst0        <= '0;
      outst1        <= '0;
      err_underflow <= 1'b0;
      m.arvalid     <= 1'b0;
      m.araddr      <= '0;
      m.arid        <= '0;
      m.arlen       <= '0;
      m.arsize      <= '0;
    end else begin
      outst0        <= next_cnt(outst0, gnt0, dec0);
      outst1        <= next_cnt(outst1, gnt1, dec1);
      err_underflow <= err_underflow || (dec0 && outst0 == '0) || (dec1 && outst1 == '0);
      if (gnt0 || gnt1) begin
        state     <= ISSUE;
        m.arvalid <= 1'b1;
        rr_last   <= gnt1;
        m.araddr  <= gnt1 ? s1.araddr : s0.araddr;
        m.arid    <= gnt1 ? {1'b1, s1.arid} : {1'b0, s0.arid};
        m.arlen   <= gnt1 ? s1.arlen : s0.arlen;
        m.arsize  <= gnt1 ? s1.arsize : s0.arsize;
      end else if (state == ISSUE && m.arready) begin
        state     <= IDLE;
        m.arvalid <= 1'b0;
      end
    end
  end
`ifdef CL_DRAM_RD_ARB_STATS_EN
  logic blk;
  assign blk = (s0.arvalid && outst0 == MAX_C) || (s1.arvalid && outst1 == MAX_C);
  always_ff @(posedge aclk or posedge areset) begin
    if (areset || stat_clr) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_block  <= '0;
    end else begin
      if (gnt0 && stat_grant0 != '1) stat_grant0 <= stat_grant0 + 1'b1;
      if (gnt1 && stat_grant1 != '1) stat_grant1 <= stat_grant1 + 1'b1;
      if (blk && stat_block != '1) stat_block <= stat_block + 1'b1;
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_grant0 = '0;
  assign stat_grant1 = '0;
  assign stat_block  = '0;
`endif
endmodule
